// File: rtl/axi_fsrc_sequencer_pkg.sv
// Shared types and limits for the FSRC sequencer core-clock engine.
package axi_fsrc_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

  localparam int MAX_CTRL_WIDTH    = 64;
  localparam int MAX_COUNTER_WIDTH = 16;
  localparam int MAX_NUM_TRIG      = 4;
  localparam int PERIOD_W          = 32;

  // Programmed period of 0 behaves like 1 so the counter always advances.
  function automatic logic [PERIOD_W-1:0] seq_len_eff(input logic [PERIOD_W-1:0] cnt);
    return (cnt == '0) ? PERIOD_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/axi_fsrc_sequencer_trig_gen.sv
// One trigger channel: pulses at two offsets within each period while running,
// otherwise forwards the manual level; output is registered either way.
module axi_fsrc_sequencer_trig_gen
  import axi_fsrc_sequencer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     run,
  input  logic [PERIOD_W-1:0]      period_cnt,
  input  logic [COUNTER_WIDTH-1:0] first_cnt,
  input  logic [COUNTER_WIDTH-1:0] second_cnt,
  input  logic                     manual,
  output logic                     trig_out
);

  logic [PERIOD_W-1:0] first_ext;
  logic [PERIOD_W-1:0] second_ext;
  logic                hit;

  assign first_ext  = PERIOD_W'(first_cnt);
  assign second_ext = PERIOD_W'(second_cnt);
  assign hit        = (period_cnt == first_ext) || (period_cnt == second_ext);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trig_out <= 1'b0;
    end else begin
      trig_out <= run ? hit : manual;
    end
  end

endmodule

// File: rtl/axi_fsrc_sequencer_ctrl.sv
// FSRC sequencer engine: start/trigger FSM, period counter, period-aligned GPIO,
// per-channel trigger pulses, periodic TX accumulator reset and delayed RX enable.
module axi_fsrc_sequencer_ctrl
  import axi_fsrc_sequencer_pkg::*;
#(
  parameter int CTRL_WIDTH    = 40,
  parameter int COUNTER_WIDTH = 4,
  parameter int NUM_TRIG      = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              seq_en,
  input  logic                              seq_start,
  input  logic                              seq_ext_trig_en,
  input  logic                              seq_ext_trig,
  input  logic                              ext_trig_in,
  input  logic [31:0]                       seq_gpio_change_cnt,
  input  logic [CTRL_WIDTH-1:0]             seq_gpio_w,
  input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt,
  input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] second_trig_cnt,
  input  logic [15:0]                       seq_tx_accum_reset_cnt,
  input  logic [COUNTER_WIDTH-1:0]          seq_rx_delay_cnt,
  input  logic [NUM_TRIG-1:0]               trig_manual,
  output logic [CTRL_WIDTH-1:0]             dut_gpio_out,
  output logic [NUM_TRIG-1:0]               trig_out,
  output logic                              tx_accum_reset,
  output logic                              rx_enable,
  output logic                              period_strobe,
  output logic                              seq_busy
);

  if (CTRL_WIDTH > MAX_CTRL_WIDTH || COUNTER_WIDTH > MAX_COUNTER_WIDTH ||
      NUM_TRIG > MAX_NUM_TRIG) begin : g_param_check
    $error("axi_fsrc_sequencer_ctrl: parameter exceeds supported maximum");
  end

  seq_state_t state_q, state_d;

  logic                     seq_start_p1;
  logic                     ext_sync_p1, ext_sync_p2;
  logic                     trig_lvl_p1;
  logic                     start_edge, trig_lvl, trig_edge;
  logic                     run_go;
  logic [PERIOD_W-1:0]      period_cnt_q, period_len_q, len_now;
  logic [15:0]              period_idx_q;
  logic                     period_start, period_end;
  logic [COUNTER_WIDTH-1:0] rx_cnt_q;

  // Input stage: edge detectors and external trigger synchroniser
  assign start_edge = seq_start & ~seq_start_p1;
  assign trig_lvl   = ext_sync_p2 | seq_ext_trig;
  assign trig_edge  = trig_lvl & ~trig_lvl_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_start_p1 <= 1'b0;
      ext_sync_p1  <= 1'b0;
      ext_sync_p2  <= 1'b0;
      trig_lvl_p1  <= 1'b0;
    end else begin
      seq_start_p1 <= seq_start;
      ext_sync_p1  <= ext_trig_in;
      ext_sync_p2  <= ext_sync_p1;
      trig_lvl_p1  <= trig_lvl;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!seq_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_edge) state_d = seq_ext_trig_en ? ARMED : RUN;
        ARMED:   if (trig_edge)  state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Dropping seq_en also gates this cycle's output updates so nothing in flight escapes
  assign run_go       = (state_q == RUN) && seq_en;
  assign seq_busy     = (state_q != IDLE);
  assign period_start = (period_cnt_q == '0);
  assign len_now      = period_start ? seq_len_eff(seq_gpio_change_cnt) : period_len_q;
  assign period_end   = (period_cnt_q == len_now - PERIOD_W'(1));

  // Counter stage: period position, period index and RX delay count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_cnt_q <= '0;
      period_len_q <= PERIOD_W'(1);
      period_idx_q <= '0;
      rx_cnt_q     <= '0;
    end else if (!run_go) begin
      period_cnt_q <= '0;
      period_idx_q <= '0;
      rx_cnt_q     <= '0;
    end else begin
      if (period_start) period_len_q <= len_now;
      if (period_end) begin
        period_cnt_q <= '0;
        if (seq_tx_accum_reset_cnt == '0 ||
            period_idx_q >= seq_tx_accum_reset_cnt - 16'd1)
          period_idx_q <= '0;
        else
          period_idx_q <= period_idx_q + 16'd1;
      end else begin
        period_cnt_q <= period_cnt_q + PERIOD_W'(1);
      end
      if (rx_cnt_q != '1) rx_cnt_q <= rx_cnt_q + COUNTER_WIDTH'(1);
    end
  end

  // Output stage: registered period-aligned outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dut_gpio_out   <= '0;
      period_strobe  <= 1'b0;
      tx_accum_reset <= 1'b0;
      rx_enable      <= 1'b0;
    end else begin
      if (run_go && period_start) dut_gpio_out <= seq_gpio_w;
      period_strobe  <= run_go && period_start;
      tx_accum_reset <= run_go && period_start && (period_idx_q == '0) &&
                        (seq_tx_accum_reset_cnt != '0);
      rx_enable      <= run_go && (rx_cnt_q >= seq_rx_delay_cnt);
    end
  end

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
    axi_fsrc_sequencer_trig_gen #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_trig_gen (
      .clk        (clk),
      .resetn     (resetn),
      .run        (run_go),
      .period_cnt (period_cnt_q),
      .first_cnt  (first_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .second_cnt (second_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .manual     (trig_manual[i]),
      .trig_out   (trig_out[i])
    );
  end

endmodule

// File: tb/tb_axi_fsrc_sequencer_ctrl.sv
// Directed bench for axi_fsrc_sequencer_ctrl with a cycle-stamped pulse scoreboard.
module tb_axi_fsrc_sequencer_ctrl;

  localparam int CW = 40;
  localparam int KW = 4;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          seq_en = 1'b0;
  logic          seq_start = 1'b0;
  logic          seq_ext_trig_en = 1'b0;
  logic          seq_ext_trig = 1'b0;
  logic          ext_trig_in = 1'b0;
  logic [31:0]   seq_gpio_change_cnt = 32'd8;
  logic [CW-1:0] seq_gpio_w = '0;
  logic [NT*KW-1:0] first_trig_cnt = 16'hFFFF;
  logic [NT*KW-1:0] second_trig_cnt = 16'hFFFF;
  logic [15:0]   seq_tx_accum_reset_cnt = 16'd0;
  logic [KW-1:0] seq_rx_delay_cnt = '0;
  logic [NT-1:0] trig_manual = '0;
  logic [CW-1:0] dut_gpio_out;
  logic [NT-1:0] trig_out;
  logic          tx_accum_reset, rx_enable, period_strobe, seq_busy;

  axi_fsrc_sequencer_ctrl #(.CTRL_WIDTH(CW), .COUNTER_WIDTH(KW), .NUM_TRIG(NT)) dut (
    .clk(clk), .resetn(resetn), .seq_en(seq_en), .seq_start(seq_start),
    .seq_ext_trig_en(seq_ext_trig_en), .seq_ext_trig(seq_ext_trig),
    .ext_trig_in(ext_trig_in), .seq_gpio_change_cnt(seq_gpio_change_cnt),
    .seq_gpio_w(seq_gpio_w), .first_trig_cnt(first_trig_cnt),
    .second_trig_cnt(second_trig_cnt), .seq_tx_accum_reset_cnt(seq_tx_accum_reset_cnt),
    .seq_rx_delay_cnt(seq_rx_delay_cnt), .trig_manual(trig_manual),
    .dut_gpio_out(dut_gpio_out), .trig_out(trig_out), .tx_accum_reset(tx_accum_reset),
    .rx_enable(rx_enable), .period_strobe(period_strobe), .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;
  int strobe_q[$];
  int tx_q[$];
  int t0_q[$];
  int t1_q[$];
  bit mon_en = 1'b0;
  bit mon_trig = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulse scoreboard: every observed pulse must match the next expected cycle stamp
  always @(negedge clk) begin
    if (mon_en) begin
      if (period_strobe) begin
        if (strobe_q.size() != 0) check("strobe_cycle", cyc, strobe_q.pop_front());
        else check("strobe_extra", period_strobe, 1'b0);
      end
      if (tx_accum_reset) begin
        if (tx_q.size() != 0) check("tx_cycle", cyc, tx_q.pop_front());
        else check("tx_extra", tx_accum_reset, 1'b0);
      end
      if (mon_trig) begin
        if (trig_out[0]) begin
          if (t0_q.size() != 0) check("trig0_cycle", cyc, t0_q.pop_front());
          else check("trig0_extra", trig_out[0], 1'b0);
        end
        if (trig_out[1]) begin
          if (t1_q.size() != 0) check("trig1_cycle", cyc, t1_q.pop_front());
          else check("trig1_extra", trig_out[1], 1'b0);
        end
        if (trig_out[3:2] != 2'b00) check("trig23_extra", trig_out[3:2], 2'b00);
      end
    end
  end

  task automatic queues_empty(input string tag);
    check({tag, "_strobe_left"}, strobe_q.size(), 0);
    check({tag, "_tx_left"}, tx_q.size(), 0);
    check({tag, "_t0_left"}, t0_q.size(), 0);
    check({tag, "_t1_left"}, t1_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a, b;
    @(negedge clk);
    check("rst_gpio", dut_gpio_out, '0);
    check("rst_trig", trig_out, '0);
    check("rst_tx", tx_accum_reset, 1'b0);
    check("rst_rx", rx_enable, 1'b0);
    check("rst_strobe", period_strobe, 1'b0);
    check("rst_busy", seq_busy, 1'b0);
    resetn = 1'b1;
    step(2);
    mon_en = 1'b1;

    // Basic run, L=8, no trigger wait
    seq_gpio_change_cnt = 32'd8;
    seq_gpio_w = 40'hA5;
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    strobe_q.push_back(t + 2); strobe_q.push_back(t + 10); strobe_q.push_back(t + 18);
    step(1);
    seq_start = 1'b0;
    check("t1_busy", seq_busy, 1'b1);
    check("t1_gpio_pre", dut_gpio_out, '0);
    step(1);
    check("t1_gpio_a5", dut_gpio_out, 40'hA5);
    goto(t + 20);
    seq_en = 1'b0;
    step(1);
    check("t1_busy_idle", seq_busy, 1'b0);
    check("t1_gpio_hold", dut_gpio_out, 40'hA5);
    queues_empty("t1");

    // Trigger offsets: ch0 2/5, ch1 2/2, ch2 9/9 never fires at L=8
    first_trig_cnt  = 16'hF922;
    second_trig_cnt = 16'hF925;
    seq_gpio_w = 40'h5A;
    step(1);
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      strobe_q.push_back(t + 2 + 8 * k);
      t0_q.push_back(t + 4 + 8 * k);
      t0_q.push_back(t + 7 + 8 * k);
      t1_q.push_back(t + 4 + 8 * k);
    end
    step(1);
    seq_start = 1'b0;
    goto(t + 24);
    seq_en = 1'b0;
    step(2);
    queues_empty("t2");

    // Trigger-gated start via external pin, then via software trigger
    first_trig_cnt  = 16'hFFFF;
    second_trig_cnt = 16'hFFFF;
    seq_gpio_w = 40'h3C;
    seq_ext_trig_en = 1'b1;
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    step(1);
    seq_start = 1'b0;
    check("t3_armed_busy", seq_busy, 1'b1);
    goto(t + 4);
    check("t3_armed_gpio", dut_gpio_out, 40'h5A);
    check("t3_armed_rx", rx_enable, 1'b0);
    check("t3_armed_trig", trig_out, '0);
    ext_trig_in = 1'b1;
    a = cyc;
    strobe_q.push_back(a + 4);
    goto(a + 3);
    check("t3_pre_run_gpio", dut_gpio_out, 40'h5A);
    check("t3_pre_run_rx", rx_enable, 1'b0);
    step(1);
    check("t3_run_gpio", dut_gpio_out, 40'h3C);
    check("t3_run_rx", rx_enable, 1'b1);
    ext_trig_in = 1'b0;
    goto(a + 6);
    seq_en = 1'b0;
    goto(a + 10);
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    step(1);
    seq_start = 1'b0;
    check("t3_sw_armed_busy", seq_busy, 1'b1);
    goto(t + 3);
    seq_ext_trig = 1'b1;
    b = cyc;
    strobe_q.push_back(b + 2);
    step(1);
    seq_ext_trig = 1'b0;
    goto(b + 4);
    seq_en = 1'b0;
    seq_ext_trig_en = 1'b0;
    step(1);
    queues_empty("t3");

    // TX reset every 3 periods of L=4, RX delay 5
    seq_gpio_change_cnt = 32'd4;
    seq_tx_accum_reset_cnt = 16'd3;
    seq_rx_delay_cnt = 4'd5;
    seq_gpio_w = 40'h11;
    step(1);
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 8; k++) strobe_q.push_back(t + 1 + 4 * k);
    tx_q.push_back(t + 1); tx_q.push_back(t + 13); tx_q.push_back(t + 25);
    step(1);
    seq_start = 1'b0;
    goto(t + 5);
    check("t4_rx_low", rx_enable, 1'b0);
    step(1);
    check("t4_rx_rise", rx_enable, 1'b1);
    goto(t + 30);
    check("t4_rx_hold", rx_enable, 1'b1);
    seq_en = 1'b0;
    step(1);
    check("t4_rx_clear", rx_enable, 1'b0);
    queues_empty("t4");
    seq_tx_accum_reset_cnt = 16'd0;
    seq_rx_delay_cnt = 4'd0;

    // seq_en dropped with ch0 pulse pending
    seq_gpio_change_cnt = 32'd8;
    first_trig_cnt  = 16'hFFF5;
    second_trig_cnt = 16'hFFF5;
    seq_gpio_w = 40'h77;
    step(1);
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    strobe_q.push_back(t + 2);
    step(1);
    seq_start = 1'b0;
    goto(t + 5);
    check("t5_rx_run", rx_enable, 1'b1);
    step(1);
    seq_en = 1'b0;
    mon_trig = 1'b0;
    trig_manual = 4'b1010;
    step(1);
    check("t5_busy", seq_busy, 1'b0);
    check("t5_trig_manual", trig_out, 4'b1010);
    check("t5_gpio_hold", dut_gpio_out, 40'h77);
    check("t5_rx_low", rx_enable, 1'b0);
    check("t5_strobe", period_strobe, 1'b0);
    trig_manual = 4'b0000;
    step(2);
    mon_trig = 1'b1;
    queues_empty("t5");

    // Reset mid-run, restart timing, then L=0
    first_trig_cnt  = 16'hFFFF;
    second_trig_cnt = 16'hFFFF;
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    strobe_q.push_back(t + 2);
    step(1);
    seq_start = 1'b0;
    goto(t + 4);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("t6_rst_gpio", dut_gpio_out, '0);
    check("t6_rst_trig", trig_out, '0);
    check("t6_rst_rx", rx_enable, 1'b0);
    check("t6_rst_busy", seq_busy, 1'b0);
    check("t6_rst_strobe", period_strobe, 1'b0);
    check("t6_rst_tx", tx_accum_reset, 1'b0);
    step(2);
    resetn = 1'b1;
    step(1);
    mon_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    strobe_q.push_back(t + 2); strobe_q.push_back(t + 10);
    step(1);
    seq_start = 1'b0;
    check("t6_busy", seq_busy, 1'b1);
    check("t6_gpio_pre", dut_gpio_out, '0);
    step(1);
    check("t6_gpio", dut_gpio_out, 40'h77);
    goto(t + 12);
    seq_en = 1'b0;
    step(1);
    queues_empty("t6a");
    seq_gpio_change_cnt = 32'd0;
    seq_en = 1'b1;
    seq_start = 1'b1;
    t = cyc;
    for (int k = 2; k <= 7; k++) strobe_q.push_back(t + k);
    step(1);
    seq_start = 1'b0;
    goto(t + 7);
    seq_en = 1'b0;
    step(2);
    queues_empty("t6b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_fsrc_sequencer_ctrl.md
Name: axi_fsrc_sequencer_ctrl

Overview:
Core-clock sequencing engine for the FSRC sequencer. It consumes the clk-domain control fields produced by the sequencer register map and runs a timed sequence. Each run is armed by a software start, optionally gated by an external or software trigger. It produces period-aligned GPIO words for the DUT, per-channel trigger pulses, TX accumulator resets and a delayed RX enable.

Parameters:
CTRL_WIDTH, 40, width of DUT GPIO word (≤64)
COUNTER_WIDTH, 4, width of trigger/delay counts (≤16)
NUM_TRIG, 4, number of trigger outputs (≤4)

Ports:
clk  in  1  core clock
resetn  in  1  async active-low reset
seq_en  in  1  sequencer enable; low forces IDLE
seq_start  in  1  start request, rising-edge sensitive
seq_ext_trig_en  in  1  1 = wait for trigger after start
seq_ext_trig  in  1  software trigger level, rising-edge sensitive
ext_trig_in  in  1  asynchronous external trigger pin
seq_gpio_change_cnt  in  32  period length in clk cycles
seq_gpio_w  in  CTRL_WIDTH  GPIO word to apply at period starts
first_trig_cnt  in  NUM_TRIG×COUNTER_WIDTH  first pulse offset per trigger
second_trig_cnt  in  NUM_TRIG×COUNTER_WIDTH  second pulse offset per trigger
seq_tx_accum_reset_cnt  in  16  TX reset every N periods; 0 = off
seq_rx_delay_cnt  in  COUNTER_WIDTH  RX enable delay after run start
trig_manual  in  NUM_TRIG  trig_out levels driven while not RUN
dut_gpio_out  out  CTRL_WIDTH  GPIO word to DUT
trig_out  out  NUM_TRIG  trigger outputs
tx_accum_reset  out  1  1-cycle TX accumulator reset pulse
rx_enable  out  1  RX capture enable
period_strobe  out  1  1-cycle pulse at each period start
seq_busy  out  1  high in ARMED or RUN

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE→ARMED: seq_en=1, start edge, ext_trig_en=1.
  - IDLE→RUN: seq_en=1, start edge, ext_trig_en=0.
  - ARMED→RUN: trigger event.
  - Any state→IDLE: seq_en=0, effective the next cycle.
- Start edge: seq_start=1 at cycle t with the previous sample 0. Start edges in ARMED or RUN are ignored.
- Trigger event: rising edge of (2-FF-synchronised ext_trig_in OR seq_ext_trig). In ARMED, the trigger edge is sampled at t and the state is RUN at t+1. Trigger events outside ARMED are ignored.
- Run timing: state is RUN at cycle R, with period_cnt=0 and period_idx=0 at R.
- Period counter:
  - Period length L = latched seq_gpio_change_cnt. Values 0 and 1 both give L=1.
  - L is latched when period_cnt=0; a mid-period change takes effect at the next period.
  - period_cnt counts 0..L-1, then wraps to 0 and period_idx increments.
- GPIO: registered from the period start.
  - At R+1+k·L: dut_gpio_out <= seq_gpio_w and period_strobe=1 for 1 cycle.
  - dut_gpio_out holds its value in IDLE and ARMED; no return to 0 on stop.
- Triggers, per channel i: trig_out[i] pulses 1 cycle at R+1+k·L+c for c = first_trig_cnt[i] and c = second_trig_cnt[i].
  - Equal first/second counts give a single pulse.
  - Counts ≥ L never fire.
  - Counts are zero-extended against period_cnt.
  - Outside RUN, trig_out = trig_manual, registered with 1-cycle latency.
- TX reset: with N=seq_tx_accum_reset_cnt≠0, tx_accum_reset pulses coincident with period_strobe when period_idx mod N = 0. The first pulse is at R+1. period_idx wraps at N-1.
- RX: rx_enable rises at R+1+seq_rx_delay_cnt, stays high while in RUN and clears the cycle after leaving RUN.
- Leaving RUN mid-period:
  - Any in-flight pulse is suppressed.
  - Counters clear.
  - A new start restarts cleanly from period_cnt=0.

Decomposition:
- Package axi_fsrc_sequencer_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, ARMED, RUN}.
  - Localparams for maximum CTRL_WIDTH, COUNTER_WIDTH and NUM_TRIG.
- Sub-module axi_fsrc_sequencer_trig_gen: one trigger channel, handling the compare of period_cnt against two offsets and the registered pulse/manual mux. Instantiated NUM_TRIG times in a generate loop.

Test Plan:
- L=8, gpio_w=0xA5, no ext trig, start at t: RUN at t+1; dut_gpio_out=0xA5 and period_strobe at t+2, t+10, t+18.
- L=8, first=2, second=5 on ch0, second=2 on ch1: ch0 pulses at t+4 and t+7 each period; ch1 pulses once per period at t+4; a count of 9 never fires.
- ext_trig_en=1, start, pulse ext_trig_in: busy during ARMED, no outputs; RUN 3 cycles after the pin rising edge; a seq_ext_trig edge alone also arms RUN.
- N=3, L=4, rx_delay=5: tx_accum_reset at R+1, R+13, R+25; rx_enable rises at R+6.
- seq_en dropped mid-period with a pulse pending: IDLE next cycle, no pulse, trig_out follows trig_manual=0b1010, gpio held, rx_enable low.
- resetn asserted during RUN: all outputs 0 immediately; after release, start again gives R timing identical to the first test; L=0 gives a period_strobe every cycle.
